axi_burst_master: RTL
=====================

Name: axi_burst_master

Overview:
- Native-to-AXI4 master bridge: the initiator counterpart of ddr_slave_wrapper.
- Accepts simple native write/read burst commands and drives the AXI4 master channels (AW/W/B, AR/R) with fixed-length INCR bursts.
- Lets native-side engines (pattern generators, DMA) drive any AXI4 slave in the memory test path, including ddr_slave_wrapper.

Parameters:
DATA_WIDTH, 128, AXI/native data width (power of 2, >=8)
ADDR_WIDTH, 32, address width
ID_WIDTH, 8, AXI ID width
AXI_ID, 0, constant awid/arid value
BURST_LEN, 8, beats per burst (1..256); awlen/arlen = BURST_LEN-1
TIMEOUT_CYC, 1024, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wr_addr_en  in  1  write command strobe
wr_addr  in  ADDR_WIDTH  write burst start address (DATA_WIDTH/8 aligned)
wr_en  in  1  write data beat strobe
wr_data  in  DATA_WIDTH  write beat data
wr_datamask  in  DATA_WIDTH/8  byte enables, 1 = write (maps to wstrb)
wr_busy  out  1  write side cannot accept command/beat
wr_ack  out  1  one-cycle write completion pulse
wr_resp  out  2  bresp of completed write
rd_addr_en  in  1  read command strobe
rd_addr  in  ADDR_WIDTH  read burst start address
rd_busy  out  1  read side cannot accept command
rd_data  out  DATA_WIDTH  read beat data
rd_valid  out  1  one-cycle pulse per read beat
rd_ack  out  1  one-cycle read completion pulse
rd_resp  out  2  worst rresp seen in burst
awid/awaddr/awlen/awsize/awburst/awvalid  out  AXI widths  write address
awlock/awcache/awprot/awqos/awregion  out  1/4/3/4/4  constants 0, awcache=4'b0011
awready  in  1
wdata/wstrb/wlast/wvalid  out  AXI widths  write data
wready  in  1
bid/bresp/bvalid  in  ID_WIDTH/2/1;  bready  out  1
arid/araddr/arlen/arsize/arburst/arvalid  out  AXI widths  read address
arlock/arcache/arprot/arqos/arregion  out  as AW side
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  AXI widths;  rready  out  1

Behaviour:
- Reset: all outputs 0 except constants; both FSMs IDLE; counters cleared.
- Reset mid-burst aborts immediately. valid signals drop with no completion pulse.
- Fixed fields: awsize/arsize=log2(DATA_WIDTH/8); awburst/arburst=2'b01.
- Write FSM IDLE->ADDR->DATA->RESP->IDLE:
  - IDLE: wr_busy=0. wr_addr_en latches wr_addr, sets awvalid next cycle, goes ADDR. wr_en in IDLE is ignored.
  - ADDR: wr_busy=1; awvalid held until awready, then DATA.
  - DATA: one-entry W holding register. wr_en&&!wr_busy loads wdata/wstrb and sets wvalid. wlast=1 when beat count == BURST_LEN-1.
  - DATA busy rule: wr_busy = wvalid&&!wready. wvalid&&wready clears wvalid, or reloads it if wr_en is present in the same cycle (full throughput, 1 beat/cycle).
  - DATA exit: after the wlast handshake, go RESP. wr_busy=1 from the last-beat load onward.
  - RESP: bready=1. bvalid gives wr_ack=1 for one cycle with wr_resp=bresp, then IDLE. wr_busy falls the same cycle as wr_ack.
  - Minimum write latency: wr_addr_en to wr_ack = BURST_LEN+3 cycles with an always-ready slave.
- Read FSM IDLE->ADDR->DATA->IDLE, independent of the write FSM:
  - IDLE: rd_busy=0. rd_addr_en latches rd_addr, sets arvalid, goes ADDR. rd_busy=1 otherwise.
  - ADDR: arvalid held until arready, then DATA.
  - DATA: rready=1. Each rvalid registers rdata into rd_data and pulses rd_valid one cycle later.
  - rd_resp tracks the maximum rresp seen across the burst.
  - rlast: rd_ack pulses in the same cycle as the final rd_valid, then IDLE.
- A strobe while busy is dropped; the source must honour busy.
- Simultaneous wr_addr_en and rd_addr_en: both accepted; AW and AR issue in parallel.
- Commands are not checked for 4KB crossing; this is the source's responsibility.

Optional Feature:
- AXI_BURST_MASTER_TIMEOUT_EN defined:
  - A 16-bit watchdog counts cycles in write RESP and read DATA, resetting on every bvalid/rvalid.
  - At TIMEOUT_CYC the FSM forces wr_ack or rd_ack with resp=2'b10 (SLVERR), drops bready/rready, and returns to IDLE.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Write 0x100, BURST_LEN=8, always-ready slave, data 0..7, mask all-ones -> awaddr=0x100, awlen=7, 8 wvalid beats, wlast on beat 7, wr_ack at cycle 11, wr_resp=0.
- Slave wready toggling 50% -> wr_busy tracks stalls; no beat lost or duplicated; wstrb matches wr_datamask per beat.
- Read 0x100 after the write through ddr_slave_wrapper+simple_ddr -> 8 rd_valid pulses with data 0..7; rd_ack on the 8th; rd_resp=0.
- Read burst where beat 3 has rresp=2'b10 -> rd_resp=2'b10 at rd_ack.
- Simultaneous wr_addr_en/rd_addr_en at different addresses -> awvalid and arvalid asserted the same cycle; both complete.
- rst pulse during write beat 4 -> all valids 0 next edge, no wr_ack; the next command works. With the timeout macro and bvalid never arriving, wr_ack occurs with wr_resp=2'b10 after 1024 cycles.

Source files
------------

// File: rtl/axi_burst_master.sv
// Native-to-AXI4 master bridge: native write/read burst commands become fixed-length INCR bursts.
// Optional watchdog on the B and R channels is enabled with AXI_BURST_MASTER_TIMEOUT_EN.
module axi_burst_master #(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 32,
  parameter int ID_WIDTH    = 8,
  parameter int AXI_ID      = 0,
  parameter int BURST_LEN   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_addr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_datamask,
  output logic                    wr_busy,
  output logic                    wr_ack,
  output logic [1:0]              wr_resp,
  input  logic                    rd_addr_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_busy,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_ack,
  output logic [1:0]              rd_resp,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  output logic                    awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic [3:0]              awqos,
  output logic [3:0]              awregion,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ID_WIDTH-1:0]     arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  output logic                    arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic [3:0]              arqos,
  output logic [3:0]              arregion,
  input  logic                    arready,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;

  wr_state_t        wr_state;
  rd_state_t        rd_state;
  logic [CNT_W-1:0] beat_cnt;
  logic             last_loaded;
  logic             wr_load;
  logic             wr_timeout;
  logic             rd_timeout;
  logic             unused_ok;

  assign awid     = ID_WIDTH'(AXI_ID);
  assign awlen    = 8'(BURST_LEN - 1);
  assign awsize   = 3'($clog2(STRB_W));
  assign awburst  = 2'b01;
  assign awlock   = 1'b0;
  assign awcache  = 4'b0011;
  assign awprot   = 3'b000;
  assign awqos    = 4'b0000;
  assign awregion = 4'b0000;
  assign arid     = ID_WIDTH'(AXI_ID);
  assign arlen    = 8'(BURST_LEN - 1);
  assign arsize   = 3'($clog2(STRB_W));
  assign arburst  = 2'b01;
  assign arlock   = 1'b0;
  assign arcache  = 4'b0011;
  assign arprot   = 3'b000;
  assign arqos    = 4'b0000;
  assign arregion = 4'b0000;

  assign unused_ok = ^{bid, rid, 32'(TIMEOUT_CYC)};

  // The W holding register frees up in the same cycle it drains, so busy looks at wready directly.
  assign wr_busy = (wr_state == W_IDLE) ? 1'b0 :
                   (wr_state == W_DATA) ? (last_loaded | (wvalid & ~wready)) : 1'b1;
  assign wr_load = (wr_state == W_DATA) && wr_en && !wr_busy;

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYC - 1);
  logic [15:0] wr_wd;
  logic [15:0] rd_wd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_wd <= 16'd0;
      rd_wd <= 16'd0;
    end else begin
      if (wr_state != W_RESP || bvalid) wr_wd <= 16'd0;
      else                              wr_wd <= wr_wd + 16'd1;
      if (rd_state != R_DATA || rvalid) rd_wd <= 16'd0;
      else                              rd_wd <= rd_wd + 16'd1;
    end
  end

  assign wr_timeout = (wr_state == W_RESP) && (wr_wd == WD_LIMIT);
  assign rd_timeout = (rd_state == R_DATA) && (rd_wd == WD_LIMIT);
`else
  assign wr_timeout = 1'b0;
  assign rd_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state    <= W_IDLE;
      awaddr      <= '0;
      awvalid     <= 1'b0;
      wdata       <= '0;
      wstrb       <= '0;
      wlast       <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      beat_cnt    <= '0;
      last_loaded <= 1'b0;
      wr_ack      <= 1'b0;
      wr_resp     <= 2'b00;
    end else begin
      wr_ack <= 1'b0;
      case (wr_state)
        W_IDLE: begin
          if (wr_addr_en) begin
            awaddr   <= wr_addr;
            awvalid  <= 1'b1;
            wr_state <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (awready) begin
            awvalid     <= 1'b0;
            beat_cnt    <= '0;
            last_loaded <= 1'b0;
            wr_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_load) begin
            wdata       <= wr_data;
            wstrb       <= wr_datamask;
            wvalid      <= 1'b1;
            wlast       <= (beat_cnt == LAST_BEAT);
            last_loaded <= (beat_cnt == LAST_BEAT);
            beat_cnt    <= beat_cnt + CNT_W'(1);
          end else if (wvalid && wready) begin
            wvalid <= 1'b0;
            wlast  <= 1'b0;
            if (wlast) begin
              bready   <= 1'b1;
              wr_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready   <= 1'b0;
            wr_ack   <= 1'b1;
            wr_resp  <= bresp;
            wr_state <= W_IDLE;
          end else if (wr_timeout) begin
            bready   <= 1'b0;
            wr_ack   <= 1'b1;
            wr_resp  <= 2'b10;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read side runs independently; rready stays high for the whole data phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= R_IDLE;
      araddr   <= '0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      rd_busy  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_ack   <= 1'b0;
      rd_resp  <= 2'b00;
    end else begin
      rd_valid <= 1'b0;
      rd_ack   <= 1'b0;
      case (rd_state)
        R_IDLE: begin
          if (rd_addr_en) begin
            araddr   <= rd_addr;
            arvalid  <= 1'b1;
            rd_busy  <= 1'b1;
            rd_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (arready) begin
            arvalid  <= 1'b0;
            rready   <= 1'b1;
            rd_resp  <= 2'b00;
            rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid) begin
            rd_data  <= rdata;
            rd_valid <= 1'b1;
            if (rresp > rd_resp) rd_resp <= rresp;
            if (rlast) begin
              rready   <= 1'b0;
              rd_ack   <= 1'b1;
              rd_busy  <= 1'b0;
              rd_state <= R_IDLE;
            end
          end else if (rd_timeout) begin
            rready   <= 1'b0;
            rd_ack   <= 1'b1;
            rd_resp  <= 2'b10;
            rd_busy  <= 1'b0;
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule
